// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the multi-cycle carry-lookahead adder/subtractor.
//   - state_t : controller state encoding (IDLE, RUN, DONE)
//   - clog2   : ceiling log2 used to size the chunk index counter
// -----------------------------------------------------------------------------
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cla_block.sv
// -----------------------------------------------------------------------------
// cla_block
// Combinational BLOCK-bit carry-lookahead adder.
// Ports:
//   a_i, b_i     : BLOCK-bit operands
//   cin_i        : carry into bit 0
//   sum_o        : BLOCK-bit sum
//   cout_o       : carry out of the top bit
//   c_msb_in_o   : carry into the top bit (used for signed overflow)
// -----------------------------------------------------------------------------
module cla_block #(
    parameter int BLOCK = 8
) (
    input  logic [BLOCK-1:0] a_i,
    input  logic [BLOCK-1:0] b_i,
    input  logic             cin_i,
    output logic [BLOCK-1:0] sum_o,
    output logic             cout_o,
    output logic             c_msb_in_o
);

    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;
    logic             acc;
    logic             prop;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Each carry is expanded as a flat sum of products:
    //   c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin
    // so no carry depends on another carry signal.
    always_comb begin
        c    = '0;
        acc  = 1'b0;
        prop = 1'b1;
        c[0] = cin_i;
        for (int i = 0; i < BLOCK; i++) begin
            acc  = 1'b0;
            prop = 1'b1;
            for (int j = i; j >= 0; j--) begin
                acc  = acc | (prop & g[j]);
                prop = prop & p[j];
            end
            acc      = acc | (prop & cin_i);
            c[i+1]   = acc;
        end
    end

    assign sum_o      = p ^ c[BLOCK-1:0];
    assign cout_o     = c[BLOCK];
    assign c_msb_in_o = c[BLOCK-1];

endmodule

// File: rtl/cla_seq_adder.sv
// -----------------------------------------------------------------------------
// cla_seq_adder
// Multi-cycle WIDTH-bit adder/subtractor processing one BLOCK-bit chunk per
// clock (LSB chunk first) through a combinational carry-lookahead block.
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   start        : operation request, accepted when busy=0
//   a, b         : operands, captured on the accepting edge
//   cin          : carry-in for add (ignored for subtract)
//   sub          : 1 selects a - b, captured with the operands
//   busy         : high while chunks are being processed
//   done         : one-cycle pulse, result outputs valid
//   sum          : result (partial values visible while busy)
//   cout         : carry out of the MSB (for subtract: 1 = no borrow)
//   overflow     : signed overflow of the completed operation
//   dbg_state_o  : current controller state (debug visibility)
//
// Handshake: a request is taken on any rising edge where start=1 and busy=0
// (IDLE or DONE state); while busy=1 start is ignored and nothing is queued.
// The result is valid in the single cycle where done=1 and stays on the
// outputs until the next accepted operation begins writing chunks.
// -----------------------------------------------------------------------------
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic [1:0]       dbg_state_o
);

    localparam int NCHUNK = WIDTH / BLOCK;
    localparam int IDXW   = (clog2(NCHUNK) < 1) ? 1 : clog2(NCHUNK);

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [BLOCK-1:0]  blk_a;
    logic [BLOCK-1:0]  blk_b;
    logic [BLOCK-1:0]  blk_sum;
    logic              blk_cout;
    logic              blk_cmsb;
    logic              accept;
    logic              is_last;

    // Select the chunk addressed by idx_q from the captured operands.
    always_comb begin
        blk_a = '0;
        blk_b = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx_q == IDXW'(k)) begin
                blk_a = a_q[k*BLOCK +: BLOCK];
                blk_b = b_q[k*BLOCK +: BLOCK];
            end
        end
    end

    cla_block #(
        .BLOCK(BLOCK)
    ) u_cla_block (
        .a_i        (blk_a),
        .b_i        (blk_b),
        .cin_i      (carry_q),
        .sum_o      (blk_sum),
        .cout_o     (blk_cout),
        .c_msb_in_o (blk_cmsb)
    );

    assign accept  = start && (state_q != RUN);
    assign is_last = (idx_q == IDXW'(NCHUNK - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    // Subtraction is a + ~b + 1: invert b once here and
                    // force the initial carry, so RUN only ever adds.
                    state_d = RUN;
                    idx_d   = '0;
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub | cin;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                for (int k = 0; k < NCHUNK; k++) begin
                    if (idx_q == IDXW'(k)) begin
                        sum_d[k*BLOCK +: BLOCK] = blk_sum;
                    end
                end
                carry_d = blk_cout;
                idx_d   = idx_q + IDXW'(1);
                if (is_last) begin
                    // On the top chunk the block's carry into its MSB is
                    // the carry into bit WIDTH-1 of the full word.
                    cout_d  = blk_cout;
                    ovf_d   = blk_cmsb ^ blk_cout;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign sum         = sum_q;
    assign cout        = cout_q;
    assign overflow    = ovf_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_seq_adder
// Four adder instances (BLOCK = 8, 4, 32, 1 at WIDTH = 32) share one stimulus
// stream. A per-instance behavioural model tracks which requests are accepted
// and what the arithmetic result must be; one compare process checks every
// instance on every falling edge. Directed tests pin the model with literal
// expected values on the BLOCK=8 instance.
// -----------------------------------------------------------------------------
module tb_cla_seq_adder;

    localparam int WIDTH = 32;
    localparam int NDUT  = 4;
    localparam int BLKS [NDUT] = '{8, 4, 32, 1};

    // ---------------- clock / reset / inputs ----------------
    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             cin   = 1'b0;
    logic             sub   = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             cmp_en = 1'b0;

    always #5 clk = ~clk;

    logic             busy_w [NDUT];
    logic             done_w [NDUT];
    logic             cout_w [NDUT];
    logic             ovf_w  [NDUT];
    logic [WIDTH-1:0] sum_w  [NDUT];
    logic [1:0]       st_w   [NDUT];

    int checks = 0;
    int errors = 0;

    genvar g;
    generate
        for (g = 0; g < NDUT; g++) begin : g_dut
            cla_seq_adder #(
                .WIDTH(WIDTH),
                .BLOCK(BLKS[g])
            ) u_dut (
                .clk         (clk),
                .rst_n       (rst_n),
                .start       (start),
                .a           (a),
                .b           (b),
                .cin         (cin),
                .sub         (sub),
                .busy        (busy_w[g]),
                .done        (done_w[g]),
                .sum         (sum_w[g]),
                .cout        (cout_w[g]),
                .overflow    (ovf_w[g]),
                .dbg_state_o (st_w[g])
            );
        end
    endgenerate

    // ---------------- check helper ----------------
    task automatic chk(input string nm, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d (BLOCK=%0d) t=%0t got %h expected %h",
                     nm, k, BLKS[k], $time, got, exp);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    // Returns {overflow, cout, sum}.
    function automatic logic [33:0] ref_op(input logic [31:0] x, input logic [31:0] y,
                                           input logic ci, input logic s);
        logic [32:0] full;
        logic [31:0] yy;
        logic        c0;
        logic        ov;
        yy   = s ? ~y : y;
        c0   = s ? 1'b1 : ci;
        full = {1'b0, x} + {1'b0, yy} + {32'd0, c0};
        // Signed overflow: operands of equal sign giving a result of the other sign.
        ov   = (x[31] == yy[31]) && (full[31] != x[31]);
        return {ov, full[32], full[31:0]};
    endfunction

    function automatic int nchunk(input int k);
        return WIDTH / BLKS[k];
    endfunction

    // ---------------- behavioural model ----------------
    // phase: 0 = idle, 1..N = busy cycle number, N+1 = done cycle.
    int          phase [NDUT];
    logic [33:0] pend  [NDUT];
    logic [33:0] last  [NDUT];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NDUT; k++) begin
                phase[k] <= 0;
                pend[k]  <= '0;
                last[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NDUT; k++) begin
                if (start && !(phase[k] >= 1 && phase[k] <= nchunk(k))) begin
                    phase[k] <= 1;
                    pend[k]  <= ref_op(a, b, cin, sub);
                end else if (phase[k] == nchunk(k)) begin
                    phase[k] <= nchunk(k) + 1;
                    last[k]  <= pend[k];
                end else if (phase[k] >= 1 && phase[k] < nchunk(k)) begin
                    phase[k] <= phase[k] + 1;
                end else begin
                    phase[k] <= 0;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < NDUT; k++) begin
                logic eb, ed;
                logic [1:0] es;
                eb = (phase[k] >= 1) && (phase[k] <= nchunk(k));
                ed = (phase[k] == nchunk(k) + 1);
                es = ed ? 2'd2 : (eb ? 2'd1 : 2'd0);
                chk("busy",  k, 32'(busy_w[k]), 32'(eb));
                chk("done",  k, 32'(done_w[k]), 32'(ed));
                chk("state", k, 32'(st_w[k]),   32'(es));
                if (!eb) begin
                    chk("sum",      k, sum_w[k],         last[k][31:0]);
                    chk("cout",     k, 32'(cout_w[k]),   32'(last[k][32]));
                    chk("overflow", k, 32'(ovf_w[k]),    32'(last[k][33]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One request on the BLOCK=8 instance, checked against literal values.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic ci,
                          input logic s, input logic [31:0] es, input logic ec,
                          input logic eo, input string nm);
        int lat;
        int bc;
        @(negedge clk);
        a = x; b = y; cin = ci; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
        lat = 1;
        bc  = 0;
        while (!done_w[0] && lat < 100) begin
            if (busy_w[0]) bc++;
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"},  0, 32'(lat),       32'd5);
        chk({nm, "_busycyc"},  0, 32'(bc),        32'd4);
        chk({nm, "_sum"},      0, sum_w[0],       es);
        chk({nm, "_cout"},     0, 32'(cout_w[0]), 32'(ec));
        chk({nm, "_overflow"}, 0, 32'(ovf_w[0]),  32'(eo));
        repeat (40) @(negedge clk);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- main sequence ----------------
    logic [33:0] exp_q [$];

    initial begin
        int nd;
        logic [33:0] r;

        @(posedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        chk("reset_busy",  0, 32'(busy_w[0]), 32'd0);
        chk("reset_done",  0, 32'(done_w[0]), 32'd0);
        chk("reset_sum",   0, sum_w[0],       32'd0);
        chk("reset_cout",  0, 32'(cout_w[0]), 32'd0);
        chk("reset_ovf",   0, 32'(ovf_w[0]),  32'd0);
        chk("reset_state", 0, 32'(st_w[0]),   32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, "add_ff");
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "chain");
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "add_ovf");
        run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_neg");
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf");

        // start held high with fresh operands every cycle
        @(negedge clk);
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            if (done_w[0]) begin
                nd++;
                chk("hold_done_cycle", 0, 32'(i), (nd == 1) ? 32'd5 : 32'd10);
                r = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                chk("hold_sum",  0, sum_w[0],       r[31:0]);
                chk("hold_cout", 0, 32'(cout_w[0]), 32'(r[32]));
                chk("hold_ovf",  0, 32'(ovf_w[0]),  32'(r[33]));
            end
            a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
            start = 1'b1;
            if (i == 0 || i == 5) exp_q.push_back(ref_op(a, b, cin, sub));
            @(negedge clk);
        end
        start = 1'b0;
        chk("hold_done_count", 0, 32'(nd), 32'd2);
        repeat (40) @(negedge clk);

        // reset in the second RUN cycle
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h0F0F_0F0F; cin = 1'b1; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk("abort_busy", k, 32'(busy_w[k]), 32'd0);
            chk("abort_done", k, 32'(done_w[k]), 32'd0);
            chk("abort_sum",  k, sum_w[k],       32'd0);
            chk("abort_cout", k, 32'(cout_w[k]), 32'd0);
            chk("abort_ovf",  k, 32'(ovf_w[k]),  32'd0);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) if (done_w[k]) nd++;
        end
        chk("abort_no_done", 0, 32'(nd), 32'd0);
        run_op(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0, 32'h2143_6588, 1'b0, 1'b0, "after_abort");

        // randomized regression: all instances checked by the compare process
        for (int i = 0; i < 30000; i++) begin
            @(negedge clk);
            a     = pick();
            b     = pick();
            cin   = 1'($urandom);
            sub   = 1'($urandom);
            start = ($urandom_range(0, 3) == 0);
        end
        start = 1'b0;
        repeat (40) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
